// File: rtl/mem_arbiter.sv
// Byte-serial memory port arbiter: shares one 8-bit RAM/IO port between
// instruction fetch (32-bit reads) and the load/store buffer (1/2/4-byte
// reads and writes), with round-robin grant, IO back-pressure and read abort.
module mem_arbiter #(
    parameter logic [1:0]  IO_ADDR_HI = 2'b11,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_size,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;          // byte whose address is on mem_a
    logic [1:0]          last_idx_q, last_idx_d; // N-1 of the granted access
    logic                grant_ls_q, grant_ls_d;
    logic                last_ls_q, last_ls_d;   // last grant went to LS
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   buf_q, buf_d;           // read assembly buffer
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          dout_q, dout_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   if_data_q, if_data_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

    logic                io_stall_c;
    logic                if_done_c;
    logic                ls_done_c;
    logic                pick_ls_c;
    logic [IDX_W-1:0]    nidx_c;

    // IO writes wait while the IO buffer is full; reads abort on clear, stores do not
    assign io_stall_c = (state_q == S_WR) && (addr_q[17:16] == IO_ADDR_HI) && io_buffer_full;
    assign if_done_c  = (state_q == S_DONE) && !grant_ls_q && !clear_in;
    assign ls_done_c  = (state_q == S_DONE) && grant_ls_q && (we_q || !clear_in);
    assign nidx_c     = idx_q + IDX_W'(1);

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        grant_ls_d = grant_ls_q;
        last_ls_d  = last_ls_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        mem_a_d    = mem_a_q;
        dout_d     = dout_q;
        wr_d       = wr_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        pick_ls_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                mem_a_d = '0;
                wr_d    = 1'b0;
                if (!clear_in && (if_req || ls_req)) begin
                    pick_ls_c  = ls_req && (!if_req || !last_ls_q);
                    grant_ls_d = pick_ls_c;
                    last_ls_d  = pick_ls_c;
                    idx_d      = '0;
                    buf_d      = '0;
                    if (pick_ls_c) begin
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                        we_d    = ls_we;
                        unique case (ls_size)
                            2'd0:    last_idx_d = 2'd0;
                            2'd1:    last_idx_d = 2'd1;
                            default: last_idx_d = 2'd3;
                        endcase
                        mem_a_d = ls_addr;
                        if (ls_we) begin
                            state_d = S_WR;
                            wr_d    = 1'b1;
                            dout_d  = ls_wdata[7:0];
                        end else begin
                            state_d = S_RD;
                        end
                    end else begin
                        addr_d     = if_addr;
                        we_d       = 1'b0;
                        last_idx_d = 2'd3;
                        mem_a_d    = if_addr;
                        state_d    = S_RD;
                    end
                end
            end

            S_RD: begin
                if (clear_in) begin
                    state_d = S_IDLE;
                    mem_a_d = '0;
                end else begin
                    // Byte for address idx-1 arrives while address idx is driven
                    for (int k = 0; k < 4; k++) begin
                        if (idx_q == IDX_W'(k + 1)) begin
                            buf_d[8*k +: 8] = mem_din;
                        end
                    end
                    if (idx_q == IDX_W'(last_idx_q) + IDX_W'(1)) begin
                        state_d = S_DONE;
                        mem_a_d = '0;
                    end else begin
                        idx_d = nidx_c;
                        if (idx_q < IDX_W'(last_idx_q)) begin
                            mem_a_d = addr_q + ADDR_W'(nidx_c);
                        end else begin
                            mem_a_d = '0;
                        end
                    end
                end
            end

            S_WR: begin
                if (!io_stall_c) begin
                    if (idx_q == IDX_W'(last_idx_q)) begin
                        state_d = S_DONE;
                        wr_d    = 1'b0;
                        mem_a_d = '0;
                        dout_d  = '0;
                    end else begin
                        idx_d   = nidx_c;
                        mem_a_d = addr_q + ADDR_W'(nidx_c);
                        for (int k = 0; k < 4; k++) begin
                            if (nidx_c == IDX_W'(k)) begin
                                dout_d = wdata_q[8*k +: 8];
                            end
                        end
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                if (if_done_c) begin
                    if_data_d = buf_q;
                end
                if (ls_done_c && !we_q) begin
                    ls_rdata_d = buf_q;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            last_idx_q <= '0;
            grant_ls_q <= 1'b0;
            last_ls_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            mem_a_q    <= '0;
            dout_q     <= '0;
            wr_q       <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            grant_ls_q <= grant_ls_d;
            last_ls_q  <= last_ls_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            mem_a_q    <= mem_a_d;
            dout_q     <= dout_d;
            wr_q       <= wr_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // Strobes are gated by freeze, stall and clear; data is visible during the done cycle
    assign mem_a    = mem_a_q;
    assign mem_dout = dout_q;
    assign mem_wr   = wr_q && rdy_in && !io_stall_c;
    assign if_done  = rdy_in && if_done_c;
    assign ls_done  = rdy_in && ls_done_c;
    assign if_data  = if_done ? buf_q : if_data_q;
    assign ls_rdata = (ls_done && !we_q) ? buf_q : ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-wide RAM model behind the port.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        clear_in = 1'b0;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = 32'h0;
    logic [1:0]  ls_size = 2'd0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] ram [logic [31:0]];

    mem_arbiter #(.IO_ADDR_HI(2'b11), .ADDR_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // RAM: writes on the edge, read data one cycle after the address
    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a] = mem_dout;
    end
    always @(posedge clk_in) begin
        mem_din <= ram_rd(mem_a);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
        ram[32'h2000] = 8'hEF; ram[32'h2001] = 8'hBE; ram[32'h2002] = 8'hAD; ram[32'h2003] = 8'hDE;
        ram[32'h3002] = 8'h77;

        // 1: reset, then a single IF fetch
        repeat (5) step();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_dones", 32'({if_done, ls_done}), 32'h0);
        chk("rst_if_data", if_data, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_in = 1'b0;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_addr", mem_a, 32'h1000 + 32'(i));
            chk("t1_wr", 32'(mem_wr), 32'h0);
        end
        step(); chk("t1_done_c5", 32'(if_done), 32'h0);
        step(); chk("t1_done_c6", 32'(if_done), 32'h1);
        chk("t1_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        step(); chk("t1_done_c7", 32'(if_done), 32'h0);
        chk("t1_data_hold", if_data, 32'h0000_0513);

        // 2: simultaneous requests, LS first after reset, then IF wins the next tie
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000; ls_size = 2'd2;
        if_req = 1'b1; if_addr = 32'h1000;
        step(); chk("t2_ls_first", mem_a, 32'h2000);
        repeat (4) step();
        step(); chk("t2_ls_done", 32'({ls_done, if_done}), 32'h2);
        chk("t2_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
        ls_size = 2'd1;
        step();
        step(); chk("t2_if_second", mem_a, 32'h1000);
        repeat (4) step();
        step(); chk("t2_if_done", 32'({ls_done, if_done}), 32'h1);
        chk("t2_if_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        step();
        step(); chk("t2_half_addr", mem_a, 32'h2000);
        repeat (2) step();
        step(); chk("t2_half_done", 32'(ls_done), 32'h1);
        chk("t2_half_data", ls_rdata, 32'h0000_BEEF);
        ls_req = 1'b0;
        step();

        // 3: half-word store leaves the neighbouring byte alone
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h3000; ls_size = 2'd1; ls_wdata = 32'hABCD_1234;
        step();
        chk("t3_c1", {mem_a[23:0], mem_dout}, {24'h003000, 8'h34});
        chk("t3_c1_wr", 32'(mem_wr), 32'h1);
        step();
        chk("t3_c2", {mem_a[23:0], mem_dout}, {24'h003001, 8'h12});
        chk("t3_c2_wr", 32'(mem_wr), 32'h1);
        step();
        chk("t3_done", 32'({ls_done, mem_wr}), 32'h2);
        ls_req = 1'b0; ls_we = 1'b0;
        step();
        chk("t3_ram", {8'h00, ram_rd(32'h3002), ram_rd(32'h3001), ram_rd(32'h3000)}, 32'h0077_1234);

        // 4: IO byte store stalled three cycles by a full IO buffer
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0003_0000; ls_size = 2'd0; ls_wdata = 32'h0000_0041;
        io_buffer_full = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t4_stall_wr", 32'(mem_wr), 32'h0);
            chk("t4_stall_addr", mem_a, 32'h0003_0000);
            chk("t4_stall_done", 32'(ls_done), 32'h0);
        end
        step();
        io_buffer_full = 1'b0;
        #1;
        chk("t4_write", {23'h0, mem_wr, mem_dout}, 32'h0000_0141);
        step(); chk("t4_done", 32'(ls_done), 32'h1);
        ls_req = 1'b0; ls_we = 1'b0;
        step();
        chk("t4_ram", 32'(ram_rd(32'h0003_0000)), 32'h41);

        // 5a: clear aborts a fetch; the next fetch is served normally
        if_req = 1'b1; if_addr = 32'h1000;
        repeat (3) step();
        clear_in = 1'b1;
        #1;
        chk("t5_clr_done", 32'(if_done), 32'h0);
        step();
        clear_in = 1'b0;
        if_addr = 32'h2000;
        chk("t5_idle_addr", mem_a, 32'h0);
        chk("t5_no_partial", if_data, 32'h0000_0513);
        repeat (5) step();
        chk("t5_c9", 32'(if_done), 32'h0);
        step();
        chk("t5_c10", 32'(if_done), 32'h1);
        chk("t5_data", if_data, 32'hDEAD_BEEF);
        if_req = 1'b0;
        step();

        // 5b: clear during a word store and its done cycle has no effect
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h4000; ls_size = 2'd2; ls_wdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            step();
            clear_in = (i == 1 || i == 2);
            #1;
            chk("t5b_addr", mem_a, 32'h4000 + 32'(i));
            chk("t5b_wr", 32'(mem_wr), 32'h1);
        end
        step();
        clear_in = 1'b1;
        #1;
        chk("t5b_done", 32'(ls_done), 32'h1);
        chk("t5b_rdata_kept", ls_rdata, 32'h0000_BEEF);
        clear_in = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0;
        step();
        chk("t5b_ram", {ram_rd(32'h4003), ram_rd(32'h4002), ram_rd(32'h4001), ram_rd(32'h4000)},
            32'hCAFE_F00D);

        // 6: four-cycle freeze during a word load
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h1000; ls_size = 2'd3;
        step();
        rdy_in = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            chk("t6_frz_addr", mem_a, 32'h1000);
            chk("t6_frz_out", 32'({mem_wr, ls_done}), 32'h0);
        end
        step();
        rdy_in = 1'b1;
        repeat (4) step();
        chk("t6_c9", 32'(ls_done), 32'h0);
        chk("t6_c9_data", ls_rdata, 32'h0000_BEEF);
        step();
        chk("t6_c10", 32'(ls_done), 32'h1);
        chk("t6_data", ls_rdata, 32'h0000_0513);
        ls_req = 1'b0;
        step();

        // 7: reset in the middle of a fetch aborts it
        if_req = 1'b1; if_addr = 32'h2000;
        repeat (2) step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        if_req = 1'b0;
        chk("t7_addr", mem_a, 32'h0);
        chk("t7_if_data", if_data, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t7_no_done", 32'(if_done), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
